// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: assembles ALU command frames from an RX byte stream, fires the
// ALU for one cycle, captures its result and returns it low byte first on a
// valid/ready byte channel.
module alu_cmd_ctrl #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    OUT_WIDTH   = 2 * DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP  = 8'hCC,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = 8'hDD
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic                  ALU_EN,
  output logic [3:0]            ALU_FUN,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  input  logic [OUT_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VLD,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_READY,
  output logic                  CMD_ERR,
  output logic                  OVR_ERR
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_A    = 3'd1,
    GET_B    = 3'd2,
    GET_FUN  = 3'd3,
    ALU_RUN  = 3'd4,
    WAIT_RES = 3'd5,
    SEND_LO  = 3'd6,
    SEND_HI  = 3'd7
  } state_e;

  state_e                  state_reg,   state_next;
  logic                    alu_en_reg,  alu_en_next;
  logic [3:0]              alu_fun_reg, alu_fun_next;
  logic [DATA_WIDTH-1:0]   alu_a_reg,   alu_a_next;
  logic [DATA_WIDTH-1:0]   alu_b_reg,   alu_b_next;
  logic [OUT_WIDTH-1:0]    result_reg,  result_next;
  logic [DATA_WIDTH-1:0]   tx_data_reg, tx_data_next;
  logic                    tx_vld_reg,  tx_vld_next;
  logic                    cmd_err_reg, cmd_err_next;
  logic                    ovr_err_reg, ovr_err_next;

  // Every output comes straight from a register; the next-state logic below
  // sets each one on the transition into the state that owns it.
  assign ALU_EN    = alu_en_reg;
  assign ALU_FUN   = alu_fun_reg;
  assign ALU_A     = alu_a_reg;
  assign ALU_B     = alu_b_reg;
  assign TX_P_DATA = tx_data_reg;
  assign TX_D_VLD  = tx_vld_reg;
  assign CMD_ERR   = cmd_err_reg;
  assign OVR_ERR   = ovr_err_reg;

  // State and output registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      alu_en_reg  <= 1'b0;
      alu_fun_reg <= '0;
      alu_a_reg   <= '0;
      alu_b_reg   <= '0;
      result_reg  <= '0;
      tx_data_reg <= '0;
      tx_vld_reg  <= 1'b0;
      cmd_err_reg <= 1'b0;
      ovr_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      alu_en_reg  <= alu_en_next;
      alu_fun_reg <= alu_fun_next;
      alu_a_reg   <= alu_a_next;
      alu_b_reg   <= alu_b_next;
      result_reg  <= result_next;
      tx_data_reg <= tx_data_next;
      tx_vld_reg  <= tx_vld_next;
      cmd_err_reg <= cmd_err_next;
      ovr_err_reg <= ovr_err_next;
    end
  end

  // Next-state and next-output decode. Pulses default low; held values
  // (operands, result, TX byte) default to their current contents.
  always_comb begin
    state_next   = state_reg;
    alu_en_next  = 1'b0;
    alu_fun_next = alu_fun_reg;
    alu_a_next   = alu_a_reg;
    alu_b_next   = alu_b_reg;
    result_next  = result_reg;
    tx_data_next = tx_data_reg;
    tx_vld_next  = tx_vld_reg;
    cmd_err_next = 1'b0;
    ovr_err_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_ALU_OP) begin
            state_next = GET_A;
          end else if (RX_P_DATA == CMD_ALU_NOP) begin
            state_next = GET_FUN;
          end else begin
            cmd_err_next = 1'b1;
          end
        end
      end
      GET_A: begin
        if (RX_D_VLD) begin
          alu_a_next = RX_P_DATA;
          state_next = GET_B;
        end
      end
      GET_B: begin
        if (RX_D_VLD) begin
          alu_b_next = RX_P_DATA;
          state_next = GET_FUN;
        end
      end
      GET_FUN: begin
        // ALU_EN is raised here so that it is high exactly while in ALU_RUN.
        if (RX_D_VLD) begin
          alu_fun_next = RX_P_DATA[3:0];
          alu_en_next  = 1'b1;
          state_next   = ALU_RUN;
        end
      end
      ALU_RUN: begin
        ovr_err_next = RX_D_VLD;
        state_next   = WAIT_RES;
      end
      WAIT_RES: begin
        // Low byte is loaded together with the result so TX_D_VLD rises with
        // valid data on entry to SEND_LO.
        ovr_err_next = RX_D_VLD;
        if (ALU_OUT_VLD) begin
          result_next  = ALU_OUT;
          tx_data_next = ALU_OUT[DATA_WIDTH-1:0];
          tx_vld_next  = 1'b1;
          state_next   = SEND_LO;
        end
      end
      SEND_LO: begin
        // TX_D_VLD stays high into SEND_HI, giving one byte per cycle.
        ovr_err_next = RX_D_VLD;
        if (TX_READY) begin
          tx_data_next = result_reg[OUT_WIDTH-1:DATA_WIDTH];
          state_next   = SEND_HI;
        end
      end
      SEND_HI: begin
        ovr_err_next = RX_D_VLD;
        if (TX_READY) begin
          tx_vld_next = 1'b0;
          state_next  = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Testbench for alu_cmd_ctrl: directed frames plus randomized traffic, with a
// behavioural ALU attached and a queue-based scoreboard checking every output.
module tb_alu_cmd_ctrl;

  localparam logic [7:0] CMD_OP  = 8'hCC;
  localparam logic [7:0] CMD_NOP = 8'hDD;

  logic        CLK;
  logic        rst_n;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic [7:0]  ALU_A;
  logic [7:0]  ALU_B;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_READY;
  logic        CMD_ERR;
  logic        OVR_ERR;

  alu_cmd_ctrl dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .RX_P_DATA   (RX_P_DATA),
    .RX_D_VLD    (RX_D_VLD),
    .ALU_EN      (ALU_EN),
    .ALU_FUN     (ALU_FUN),
    .ALU_A       (ALU_A),
    .ALU_B       (ALU_B),
    .ALU_OUT     (ALU_OUT),
    .ALU_OUT_VLD (ALU_OUT_VLD),
    .TX_P_DATA   (TX_P_DATA),
    .TX_D_VLD    (TX_D_VLD),
    .TX_READY    (TX_READY),
    .CMD_ERR     (CMD_ERR),
    .OVR_ERR     (OVR_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural ALU function, shared by the attached ALU and the reference model.
  function automatic logic [15:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] f);
    case (f)
      4'h0:    return 16'(a) + 16'(b);
      4'h1:    return 16'(a) - 16'(b);
      4'h2:    return 16'(a) * 16'(b);
      4'h3:    return (b != 8'h00) ? 16'(a / b) : 16'h0000;
      4'h4:    return {8'h00, a & b};
      4'h5:    return {8'h00, a | b};
      4'h6:    return {8'h00, ~(a & b)};
      4'h7:    return {8'h00, ~(a | b)};
      4'h8:    return {8'h00, a ^ b};
      4'h9:    return {8'h00, ~(a ^ b)};
      4'hA:    return {15'h0000, a == b};
      4'hB:    return {15'h0000, a > b};
      4'hC:    return {15'h0000, a < b};
      4'hD:    return {8'h00, a >> 1};
      4'hE:    return 16'(a) << 1;
      default: return 16'h0000;
    endcase
  endfunction

  // Attached ALU: registered result one cycle after ALU_EN, junk otherwise.
  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      ALU_OUT_VLD <= 1'b0;
      ALU_OUT     <= 16'h0000;
    end else begin
      ALU_OUT_VLD <= ALU_EN;
      ALU_OUT     <= ALU_EN ? ref_alu(ALU_A, ALU_B, ALU_FUN) : 16'($urandom);
    end
  end

  // TX sink: 0 random ready, 1 always ready, 2 never ready.
  int tx_mode = 1;
  initial TX_READY = 1'b1;
  always @(posedge CLK) begin
    #2;
    case (tx_mode)
      0:       TX_READY = ($urandom_range(0, 3) != 0);
      1:       TX_READY = 1'b1;
      default: TX_READY = 1'b0;
    endcase
  end

  // Scoreboard queues filled by the stimulus side.
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] fun;
    int         cyc;
  } alu_exp_t;
  typedef struct {
    logic [7:0] data;
    bit         is_lo;
  } tx_exp_t;

  alu_exp_t alu_q[$];
  tx_exp_t  tx_q[$];
  int       cmd_q[$];
  int       ovr_q[$];
  int       rise_q[$];

  // Reference model state: operands persist across frames.
  logic [7:0] a_m = 8'h00;
  logic [7:0] b_m = 8'h00;

  // Monitor state.
  alu_exp_t   ae;
  tx_exp_t    te;
  int         ie;
  bit         prev_vld  = 1'b0;
  bit         hold      = 1'b0;
  logic [7:0] hold_data = 8'h00;
  bit         expect_hi = 1'b0;

  // Monitor: samples on the falling edge and compares against queued expectations.
  always @(negedge CLK) begin
    if (!rst_n) begin
      prev_vld  = 1'b0;
      hold      = 1'b0;
      expect_hi = 1'b0;
    end else begin
      if (ALU_EN) begin
        n_cmp++;
        if (alu_q.size() == 0) begin
          n_err++;
          $display("FAIL alu_en: unexpected pulse at cycle %0d A=%h B=%h FUN=%h, required none",
                   cyc, ALU_A, ALU_B, ALU_FUN);
        end else begin
          ae = alu_q.pop_front();
          if (ALU_A !== ae.a || ALU_B !== ae.b || ALU_FUN !== ae.fun || cyc != ae.cyc) begin
            n_err++;
            $display("FAIL alu_en: got A=%h B=%h FUN=%h cyc=%0d, required A=%h B=%h FUN=%h cyc=%0d",
                     ALU_A, ALU_B, ALU_FUN, cyc, ae.a, ae.b, ae.fun, ae.cyc);
          end
        end
      end
      if (CMD_ERR) begin
        n_cmp++;
        ie = (cmd_q.size() != 0) ? cmd_q.pop_front() : -1;
        if (ie != cyc) begin
          n_err++;
          $display("FAIL cmd_err: pulse at cycle %0d, required cycle %0d (-1 = none)", cyc, ie);
        end
      end
      if (OVR_ERR) begin
        n_cmp++;
        ie = (ovr_q.size() != 0) ? ovr_q.pop_front() : -1;
        if (ie != cyc) begin
          n_err++;
          $display("FAIL ovr_err: pulse at cycle %0d, required cycle %0d (-1 = none)", cyc, ie);
        end
      end
      if (TX_D_VLD && !prev_vld) begin
        n_cmp++;
        ie = (rise_q.size() != 0) ? rise_q.pop_front() : -1;
        if (ie != cyc) begin
          n_err++;
          $display("FAIL tx_rise: TX_D_VLD rose at cycle %0d, required cycle %0d (-1 = none)", cyc, ie);
        end
      end
      if (hold) begin
        n_cmp++;
        if (TX_D_VLD !== 1'b1 || TX_P_DATA !== hold_data) begin
          n_err++;
          $display("FAIL tx_hold: got vld=%b data=%h while stalled, required vld=1 data=%h",
                   TX_D_VLD, TX_P_DATA, hold_data);
        end
      end
      if (expect_hi) begin
        n_cmp++;
        if (TX_D_VLD !== 1'b1) begin
          n_err++;
          $display("FAIL tx_b2b: got vld=%b after low byte, required 1", TX_D_VLD);
        end
      end
      expect_hi = 1'b0;
      if (TX_D_VLD && TX_READY) begin
        n_cmp++;
        if (tx_q.size() == 0) begin
          n_err++;
          $display("FAIL tx_byte: unexpected byte %h, required none", TX_P_DATA);
        end else begin
          te = tx_q.pop_front();
          $display("tx byte %h (%s) cycle %0d", TX_P_DATA, te.is_lo ? "lo" : "hi", cyc);
          if (TX_P_DATA !== te.data) begin
            n_err++;
            $display("FAIL tx_byte: got %h, required %h", TX_P_DATA, te.data);
          end
          expect_hi = te.is_lo;
        end
      end
      hold      = TX_D_VLD && !TX_READY;
      hold_data = TX_P_DATA;
      prev_vld  = TX_D_VLD;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output int k);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    k         = cyc;
    next_cycle();
    RX_D_VLD  = 1'b0;
    RX_P_DATA = 8'($urandom);
  endtask

  task automatic gap(input int max_gap);
    repeat ($urandom_range(0, max_gap)) next_cycle();
  endtask

  task automatic do_frame(input bit is_op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] fun_byte, input int max_gap);
    int         k;
    logic [15:0] res;
    tx_exp_t    t;
    alu_exp_t   e;
    if (is_op) begin
      send_byte(CMD_OP, k);  gap(max_gap);
      send_byte(a, k);       gap(max_gap);
      send_byte(b, k);       gap(max_gap);
      a_m = a;
      b_m = b;
    end else begin
      send_byte(CMD_NOP, k); gap(max_gap);
    end
    send_byte(fun_byte, k);
    e.a = a_m; e.b = b_m; e.fun = fun_byte[3:0]; e.cyc = k + 1;
    alu_q.push_back(e);
    res = ref_alu(a_m, b_m, fun_byte[3:0]);
    t.data = res[7:0];  t.is_lo = 1'b1; tx_q.push_back(t);
    t.data = res[15:8]; t.is_lo = 1'b0; tx_q.push_back(t);
    rise_q.push_back(k + 3);
  endtask

  task automatic send_bad_cmd();
    logic [7:0] v;
    int         k;
    v = 8'($urandom);
    while (v == CMD_OP || v == CMD_NOP) v = 8'($urandom);
    send_byte(v, k);
    cmd_q.push_back(k + 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((tx_q.size() != 0 || alu_q.size() != 0) && n < 300) begin
      @(posedge CLK);
      n++;
    end
    #1;
    if (n >= 300) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle: %0d bytes still pending after 300 cycles, required 0", tx_q.size());
      tx_q.delete();
      alu_q.delete();
      rise_q.delete();
    end
  endtask

  task automatic wait_tx_vld();
    int n = 0;
    @(negedge CLK);
    while (!TX_D_VLD && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_tx_vld: TX_D_VLD got 0 for 50 cycles, required 1");
    end
    next_cycle();
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic check_reset_outputs();
    @(negedge CLK);
    chk("rst_alu_en",  16'(ALU_EN),    16'h0);
    chk("rst_alu_fun", 16'(ALU_FUN),   16'h0);
    chk("rst_alu_a",   16'(ALU_A),     16'h0);
    chk("rst_alu_b",   16'(ALU_B),     16'h0);
    chk("rst_tx_data", 16'(TX_P_DATA), 16'h0);
    chk("rst_tx_vld",  16'(TX_D_VLD),  16'h0);
    chk("rst_cmd_err", 16'(CMD_ERR),   16'h0);
    chk("rst_ovr_err", 16'(OVR_ERR),   16'h0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int k;
    rst_n     = 1'b0;
    RX_D_VLD  = 1'b0;
    RX_P_DATA = 8'h00;
    repeat (3) next_cycle();
    check_reset_outputs();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Basic add: 05 + 03 -> 08, 00.
    tx_mode = 1;
    do_frame(1'b1, 8'h05, 8'h03, 8'h00, 0);
    wait_idle();

    // Multiply with a stalled sink: FF * FF -> FE01.
    tx_mode = 2;
    do_frame(1'b1, 8'hFF, 8'hFF, 8'h02, 0);
    wait_tx_vld();
    repeat (5) next_cycle();
    tx_mode = 1;
    wait_idle();

    // NOP frame reuses A=B=FF; equality gives 0001.
    do_frame(1'b0, 8'h00, 8'h00, 8'h0A, 0);
    wait_idle();

    // Unknown command, then a normal frame.
    k = 0;
    RX_P_DATA = 8'h55;
    RX_D_VLD  = 1'b1;
    k = cyc;
    next_cycle();
    RX_D_VLD = 1'b0;
    cmd_q.push_back(k + 1);
    do_frame(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1);
    wait_idle();

    // Two bytes arriving while the low byte is stalled.
    tx_mode = 2;
    do_frame(1'b1, 8'h12, 8'h34, 8'h04, 0);
    wait_tx_vld();
    send_byte(8'hCC, k); ovr_q.push_back(k + 1);
    send_byte(8'h77, k); ovr_q.push_back(k + 1);
    tx_mode = 1;
    wait_idle();

    // Reset in the middle of a frame.
    send_byte(CMD_OP, k);
    send_byte(8'h11, k);
    rst_n = 1'b0;
    check_reset_outputs();
    next_cycle();
    rst_n = 1'b1;
    a_m = 8'h00;
    b_m = 8'h00;
    next_cycle();
    do_frame(1'b1, 8'h02, 8'h02, 8'h00, 0);
    wait_idle();

    // Randomized traffic.
    tx_mode = 0;
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        do_frame(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 2);
      end else if (r <= 7) begin
        do_frame(1'b0, 8'h00, 8'h00, 8'($urandom), 2);
      end else if (r == 8) begin
        send_bad_cmd();
      end else begin
        do_frame(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1);
        repeat ($urandom_range(0, 2)) next_cycle();
        send_byte(8'($urandom), k);
        ovr_q.push_back(k + 1);
      end
      wait_idle();
      gap(2);
    end
    tx_mode = 1;
    repeat (5) next_cycle();

    chk("end_alu_q",  16'(alu_q.size()),  16'h0);
    chk("end_tx_q",   16'(tx_q.size()),   16'h0);
    chk("end_cmd_q",  16'(cmd_q.size()),  16'h0);
    chk("end_ovr_q",  16'(ovr_q.size()),  16'h0);
    chk("end_rise_q", 16'(rise_q.size()), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
